hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Central stall/flush controller for the 5-stage MIPS pipeline. It watches decode and execute hazard sources (load-use, branch misprediction, multi-cycle multiply/divide) and drives the PC write enable, the IF/ID register's `Fetch_Enable`/`Flush` pair, the ID/EX flush, and the fetch redirect select. It also keeps stall and flush event counters for performance debug. It sits beside the datapath and has no data path of its own.

## Interface
Parameters:
- `MD_LATENCY`, default 4: cycles an issued mult/div occupies HI/LO, counted from the cycle after `MulDivStartE`; legal range 2..15.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `Clk`  in  1  pipeline clock; all state updates on posedge.
- `Reset`  in  1  synchronous, active-high; sampled on posedge `Clk`.
- `RsD`, `RtD`  in  5  source registers of the instruction in decode.
- `UsesHiLoD`  in  1  decode instruction reads HI/LO or is itself mult/div.
- `RtE`  in  5  destination of the instruction in execute.
- `MemReadE`  in  1  execute instruction is a load.
- `MulDivStartE`  in  1  mult/div is in execute this cycle.
- `BranchE`  in  1  execute instruction is a conditional branch.
- `TakenE`  in  1  resolved branch outcome.
- `PredictE`  in  1  prediction carried down from fetch (`predictD` pipelined).
- `PCWriteF`  out  1  PC register load enable.
- `Fetch_Enable`  out  1  IF/ID load enable.
- `Flush`  out  1  IF/ID flush.
- `FlushE`  out  1  ID/EX flush (bubble insert).
- `RedirectF`  out  1  selects the corrected branch PC into fetch.
- `StallCount`  out  `CNT_W`  cycles with `PCWriteF`=0 outside reset.
- `FlushCount`  out  `CNT_W`  mispredict flush events.

## Operation
- Control outputs are combinational from the current inputs plus registered state. Counters and the FSM are registered.
- FSM states:
  - RUN: no mult/div outstanding.
  - MD_BUSY: down-counter `md_cnt` (4 bits) is nonzero.
- FSM transitions:
  - `MulDivStartE` in any state: load `md_cnt` with `MD_LATENCY`, go to MD_BUSY.
  - In MD_BUSY without a start: `md_cnt` decrements. When it reaches 1, the next state is RUN with `md_cnt`=0.
- Hazard conditions:
  - mispredict = `BranchE` & (`TakenE` != `PredictE`).
  - md_stall = (state==MD_BUSY | `MulDivStartE`) & `UsesHiLoD`.
  - ld_stall = `MemReadE` & (`RtE`!=0) & (`RtE`==`RsD` | `RtE`==`RtD`).
- Priority is mispredict > md_stall > ld_stall.
  - mispredict: `RedirectF`=1, `PCWriteF`=1, `Flush`=1, `FlushE`=1, `Fetch_Enable`=0.
  - md_stall or ld_stall: `PCWriteF`=0, `Fetch_Enable`=0, `FlushE`=1, `Flush`=0, `RedirectF`=0.
  - none: `PCWriteF`=1, `Fetch_Enable`=1, `Flush`=0, `FlushE`=0, `RedirectF`=0.
- A mispredict does not cancel an outstanding mult/div. That instruction is older than the branch, so `md_cnt` keeps counting.
- `StallCount` increments on every non-reset cycle with `PCWriteF`=0. `FlushCount` increments on every mispredict cycle. Both wrap modulo 2^`CNT_W`.

## Timing
- While `Reset`=1: `PCWriteF`=0, `Fetch_Enable`=0, `Flush`=1, `FlushE`=1, `RedirectF`=0. These values are forced combinationally.
- Registered state after a `Reset` edge: state=RUN, `md_cnt`=0, `StallCount`=0, `FlushCount`=0.
- Reset wins over every hazard input in the same cycle. Reset mid-MD_BUSY returns to RUN.
- Load-use stall lasts exactly 1 cycle. On the next edge the load has moved to MEM and forwarding covers it.
- Mult/div stall: after `MulDivStartE` at cycle t, `UsesHiLoD` stalls through cycle t+`MD_LATENCY`. It releases at t+`MD_LATENCY`+1.
- Mispredict costs exactly 2 bubbles: the IF/ID flush plus the ID/EX flush, both taking effect on the same edge.
- Mispredict coincident with load-use or md_stall: the flush wins, and the stalled decode instruction is discarded by `Flush`.

## Structure
- Shared pipeline package holds:
  - FSM state encoding (`HS_RUN`, `HS_MD_BUSY`).
  - `REG_ZERO` = 5'd0.
  - Default `MD_LATENCY`.
- Split out one sub-module, `muldiv_busy_timer`:
  - Contains the load/decrement counter and the busy flag.
  - Reusable by the HI/LO forwarding logic.
- Hazard detection and priority muxing stay in the top module.

## Test plan
- Reset sequencing:
  - Stimulus: `Reset`=1 for 2 cycles with `MemReadE`=1 and `RtE`=`RsD`=5.
  - Required: `Flush`=`FlushE`=1 and `PCWriteF`=0 throughout; after release, counters read 0 and `PCWriteF`=1.
- Load-use:
  - Stimulus: `MemReadE`=1, `RtE`=8, `RtD`=8 for one cycle.
  - Required: `PCWriteF`=0, `Fetch_Enable`=0, `FlushE`=1 for 1 cycle, then all clear; `StallCount`=1.
  - Repeat with `RtE`=0; required: no stall.
- Mispredict priority:
  - Stimulus: `BranchE`=1, `TakenE`=1, `PredictE`=0 together with a load-use match.
  - Required: `RedirectF`=`Flush`=`FlushE`=1, `PCWriteF`=1; `FlushCount`=1, `StallCount` unchanged.
- Mult/div window:
  - Stimulus: `MulDivStartE` at cycle 10 with `MD_LATENCY`=4, and `UsesHiLoD`=1 from cycle 10 onward.
  - Required: stall cycles 10–14, release at 15; `StallCount`=5.
- Mult/div across mispredict:
  - Stimulus: `MulDivStartE` at cycle 3, then a mispredict at cycle 4.
  - Required: flush at cycle 4; MD_BUSY persists and `UsesHiLoD` still stalls through cycle 7.
- Counter wrap:
  - Stimulus: `CNT_W`=4, 17 mispredicts.
  - Required: `FlushCount`=1.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline definitions for the stall/flush controller and its mult/div timer.
package hazard_sequencer_pkg;

  typedef enum logic {
    HS_RUN     = 1'b0,
    HS_MD_BUSY = 1'b1
  } hs_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 4;

endpackage

// File: rtl/muldiv_busy_timer.sv
// Tracks an outstanding mult/div: loads MD_LATENCY on start, counts down, busy while nonzero.
module muldiv_busy_timer
  import hazard_sequencer_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  hs_state_e  state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    // A new start always restarts the window, even while already busy.
    if (start) begin
      state_d  = HS_MD_BUSY;
      md_cnt_d = 4'(MD_LATENCY);
    end else if (state_q == HS_MD_BUSY) begin
      if (md_cnt_q <= 4'd1) begin
        state_d  = HS_RUN;
        md_cnt_d = 4'd0;
      end else begin
        md_cnt_d = md_cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HS_RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy = (state_q == HS_MD_BUSY);

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller: load-use, mult/div and mispredict hazards with perf counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             UsesHiLoD,
  input  logic [4:0]       RtE,
  input  logic             MemReadE,
  input  logic             MulDivStartE,
  input  logic             BranchE,
  input  logic             TakenE,
  input  logic             PredictE,
  output logic             PCWriteF,
  output logic             Fetch_Enable,
  output logic             Flush,
  output logic             FlushE,
  output logic             RedirectF,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic md_busy, mispredict, md_stall, ld_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // A mispredict does not cancel the older mult/div, so the timer ignores flushes.
  muldiv_busy_timer #(.MD_LATENCY(MD_LATENCY)) u_md_timer (
    .clk   (Clk),
    .reset (Reset),
    .start (MulDivStartE),
    .busy  (md_busy)
  );

  assign mispredict = BranchE & (TakenE != PredictE);
  assign md_stall   = (md_busy | MulDivStartE) & UsesHiLoD;
  assign ld_stall   = MemReadE & (RtE != REG_ZERO) & ((RtE == RsD) | (RtE == RtD));

  always_comb begin
    PCWriteF     = 1'b1;
    Fetch_Enable = 1'b1;
    Flush        = 1'b0;
    FlushE       = 1'b0;
    RedirectF    = 1'b0;
    if (Reset) begin
      PCWriteF     = 1'b0;
      Fetch_Enable = 1'b0;
      Flush        = 1'b1;
      FlushE       = 1'b1;
    end else if (mispredict) begin
      RedirectF    = 1'b1;
      Flush        = 1'b1;
      FlushE       = 1'b1;
      Fetch_Enable = 1'b0;
    end else if (md_stall | ld_stall) begin
      PCWriteF     = 1'b0;
      Fetch_Enable = 1'b0;
      FlushE       = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PCWriteF)  stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (mispredict) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: a 32-bit and a 4-bit counter instance share stimulus.
module tb_hazard_sequencer;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] RsD = '0, RtD = '0, RtE = '0;
  logic       UsesHiLoD = 1'b0, MemReadE = 1'b0, MulDivStartE = 1'b0;
  logic       BranchE = 1'b0, TakenE = 1'b0, PredictE = 1'b0;

  logic        pcw, fe, fl, fle, rd;
  logic [31:0] sc, fc;
  logic        pcw4, fe4, fl4, fle4, rd4;
  logic [3:0]  sc4, fc4;

  always #5 clk = ~clk;

  hazard_sequencer #(.MD_LATENCY(LAT), .CNT_W(32)) dut (
    .Clk(clk), .Reset(Reset), .RsD(RsD), .RtD(RtD), .UsesHiLoD(UsesHiLoD),
    .RtE(RtE), .MemReadE(MemReadE), .MulDivStartE(MulDivStartE),
    .BranchE(BranchE), .TakenE(TakenE), .PredictE(PredictE),
    .PCWriteF(pcw), .Fetch_Enable(fe), .Flush(fl), .FlushE(fle), .RedirectF(rd),
    .StallCount(sc), .FlushCount(fc)
  );

  hazard_sequencer #(.MD_LATENCY(LAT), .CNT_W(4)) dut4 (
    .Clk(clk), .Reset(Reset), .RsD(RsD), .RtD(RtD), .UsesHiLoD(UsesHiLoD),
    .RtE(RtE), .MemReadE(MemReadE), .MulDivStartE(MulDivStartE),
    .BranchE(BranchE), .TakenE(TakenE), .PredictE(PredictE),
    .PCWriteF(pcw4), .Fetch_Enable(fe4), .Flush(fl4), .FlushE(fle4), .RedirectF(rd4),
    .StallCount(sc4), .FlushCount(fc4)
  );

  typedef struct {
    logic [4:0]  ctl;   // {PCWriteF, Fetch_Enable, Flush, FlushE, RedirectF}
    logic [31:0] sc, fc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, md_end = -1;
  logic [31:0] m_sc = '0, m_fc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic vec(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic uses, input logic [4:0] rte, input logic memr,
                     input logic start, input logic br, input logic tk, input logic pr);
    exp_t e;
    logic mis, mds, lds;
    @(posedge clk); #1;
    Reset = rst; RsD = rs; RtD = rt; UsesHiLoD = uses; RtE = rte; MemReadE = memr;
    MulDivStartE = start; BranchE = br; TakenE = tk; PredictE = pr;
    mis = br && (tk != pr);
    mds = (start || cyc <= md_end) && uses;
    lds = memr && rte != 5'd0 && (rte == rs || rte == rt);
    if (rst)             e.ctl = 5'b00110;
    else if (mis)        e.ctl = 5'b10111;
    else if (mds || lds) e.ctl = 5'b00010;
    else                 e.ctl = 5'b11000;
    e.sc = m_sc;
    e.fc = m_fc;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("ctl",    {27'd0, pcw, fe, fl, fle, rd}, {27'd0, e.ctl});
    chk("ctl4",   {27'd0, pcw4, fe4, fl4, fle4, rd4}, {27'd0, e.ctl});
    chk("stall",  sc, e.sc);
    chk("flush",  fc, e.fc);
    chk("stall4", {28'd0, sc4}, e.sc & 32'hF);
    chk("flush4", {28'd0, fc4}, e.fc & 32'hF);
    if (rst) begin
      m_sc = '0; m_fc = '0; md_end = -1;
    end else begin
      if (!e.ctl[4]) m_sc++;
      if (mis)       m_fc++;
      if (start)     md_end = cyc + LAT;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) vec(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held two cycles against a load-use match
    vec(1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0);
    vec(1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0);
    idle(2);
    // Load-use on Rt, then RtE=0 must not stall
    vec(0, 5'd1, 5'd8, 0, 5'd8, 1, 0, 0, 0, 0);
    idle(1);
    vec(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);
    idle(1);
    // Mispredict coincident with load-use
    vec(0, 5'd8, 5'd8, 0, 5'd8, 1, 0, 1, 1, 0);
    vec(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 1);
    vec(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 1, 1);
    idle(1);
    // Mult/div window with UsesHiLoD held high
    vec(0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) vec(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 0);
    idle(1);
    // Mult/div across a mispredict
    vec(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0, 0, 0);
    vec(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) vec(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 0);
    // Reset mid-busy returns to RUN
    vec(0, 5'd1, 5'd2, 1, 5'd3, 0, 1, 0, 0, 0);
    vec(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 0);
    vec(1, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) vec(0, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 0);
    // Counter wrap: 17 mispredicts wrap the 4-bit FlushCount to 1
    for (int i = 0; i < 17; i++) vec(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 1);
    idle(2);
    // Random mix
    for (int i = 0; i < 300; i++)
      vec($urandom_range(0, 31) == 0,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
